// File: rtl/scedma_seg_resp_if.sv
// Per-channel segment request/response bundle between the access-control stage
// (initiators, master side) and the segment responder (slave side).
interface scedma_seg_resp_if #(
    parameter int CHNLCNT = 4,
    parameter int AW      = 12,
    parameter int DW      = 32
);
    // Handshake: a channel requests with segrd|segwr and holds command, addr and wdat
    // stable until it sees segready high; the request is accepted in that cycle.
    logic [CHNLCNT-1:0]         segrd;
    logic [CHNLCNT-1:0]         segwr;
    logic [CHNLCNT-1:0][AW-1:0] segaddr;
    logic [CHNLCNT-1:0][DW-1:0] segwdat;
    logic [CHNLCNT-1:0]         segready;
    logic [CHNLCNT-1:0][DW-1:0] segrdat;
    logic [CHNLCNT-1:0]         segrdatvld;

    modport master (
        output segrd, segwr, segaddr, segwdat,
        input  segready, segrdat, segrdatvld
    );

    modport slave (
        input  segrd, segwr, segaddr, segwdat,
        output segready, segrdat, segrdatvld
    );
endinterface

// File: rtl/scedma_seg_resp.sv
// Segment responder: round-robin arbitration of CHNLCNT channels onto one
// single-port segment SRAM, with an in-order tagged read-return pipeline.
module scedma_seg_resp #(
    parameter int CHNLCNT  = 4,
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int SEGDEPTH = 4096,
    parameter int RDLAT    = 1
) (
    input  logic          clk,
    input  logic          reset,
    scedma_seg_resp_if.slave seg,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat,
    output logic          oorerr,
    output logic          proterr
);
    localparam int CW = (CHNLCNT > 1) ? $clog2(CHNLCNT) : 1;
    localparam logic [AW:0] SEG_LIMIT = (AW+1)'(SEGDEPTH);

    logic [CW-1:0]      rr_ptr;
    logic [CHNLCNT-1:0] req;
    logic [CHNLCNT-1:0] grant;
    logic               gnt_any;
    logic [CW-1:0]      gnt_id;
    logic [CW-1:0]      cand;

    logic               rd_sel;
    logic               wr_sel;
    logic [AW-1:0]      addr_sel;
    logic               in_range;
    logic               is_read;
    logic               is_write;

    logic [RDLAT-1:0]   tag_vld;
    logic [RDLAT-1:0]   tag_oor;
    logic [CW-1:0]      tag_ch [RDLAT];
    logic               ret_vld;
    logic [CW-1:0]      ret_ch;
    logic [DW-1:0]      ret_data;

    logic [CHNLCNT-1:0][DW-1:0] rdat_q;

    assign req = seg.segrd | seg.segwr;

    // First requester at or after the pointer wins; nothing is granted in reset.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 0; k < CHNLCNT; k++) begin
            cand = CW'((int'(rr_ptr) + k) % CHNLCNT);
            if (!reset && !gnt_any && req[cand]) begin
                grant[cand] = 1'b1;
                gnt_any     = 1'b1;
                gnt_id      = cand;
            end
        end
    end

    assign rd_sel   = seg.segrd[gnt_id];
    assign wr_sel   = seg.segwr[gnt_id];
    assign addr_sel = seg.segaddr[gnt_id];
    assign in_range = ({1'b0, addr_sel} < SEG_LIMIT);
    assign is_write = gnt_any & wr_sel;
    assign is_read  = gnt_any & rd_sel & ~wr_sel;

    assign seg.segready = grant;

    assign mem_ce   = gnt_any & in_range;
    assign mem_we   = is_write & in_range;
    assign mem_addr = gnt_any ? addr_sel : '0;
    assign mem_wdat = is_write ? seg.segwdat[gnt_id] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            oorerr  <= 1'b0;
            proterr <= 1'b0;
        end else begin
            oorerr  <= gnt_any & ~in_range;
            proterr <= gnt_any & rd_sel & wr_sel;
            if (gnt_any) begin
                rr_ptr <= (int'(gnt_id) == CHNLCNT - 1) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    // Out-of-range reads ride the same tag pipeline so returns stay in acceptance order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            tag_oor <= '0;
            for (int s = 0; s < RDLAT; s++) begin
                tag_ch[s] <= '0;
            end
        end else begin
            tag_vld[0] <= is_read;
            tag_oor[0] <= ~in_range;
            tag_ch[0]  <= gnt_id;
            for (int s = 1; s < RDLAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_oor[s] <= tag_oor[s-1];
                tag_ch[s]  <= tag_ch[s-1];
            end
        end
    end

    assign ret_vld  = tag_vld[RDLAT-1];
    assign ret_ch   = tag_ch[RDLAT-1];
    assign ret_data = tag_oor[RDLAT-1] ? '0 : mem_rdat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdat_q <= '0;
        end else if (ret_vld) begin
            rdat_q[ret_ch] <= ret_data;
        end
    end

    // Returning channel sees SRAM data in the return cycle; others hold their last value.
    always_comb begin
        seg.segrdatvld = '0;
        seg.segrdat    = rdat_q;
        if (ret_vld) begin
            seg.segrdatvld[ret_ch] = 1'b1;
            seg.segrdat[ret_ch]    = ret_data;
        end
    end
endmodule
